// File: rtl/jam_perm_sched.sv
// Exhaustive 8x8 assignment search: walks every worker->job permutation in
// lexicographic order, sums cost-ROM reads and tracks the minimum total and its multiplicity.
module jam_perm_sched #(
    parameter int unsigned COST_W = 7,
    parameter int unsigned N      = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [COST_W-1:0] Cost,
    output logic [2:0]        W,
    output logic [2:0]        J,
    output logic              Busy,
    output logic              Valid,
    output logic [15:0]       MatchCount,
    output logic [9:0]        MinCost
);

    localparam int unsigned IW    = 3;
    localparam int unsigned ACC_W = 10;
    localparam int unsigned CNT_W = 16;
    localparam logic [ACC_W-1:0] MIN_INIT = 10'h3FF;
    localparam logic [IW-1:0]    IDX_LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     perm [N];
    logic [IW-1:0]     perm_nxt [N];
    logic [IW-1:0]     swapped [N];
    logic [IW-1:0]     idx;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  min_cost;
    logic [CNT_W-1:0]  match_count;
    logic              has_pivot;
    int                k_i;
    int                s_i;

    // Lexicographic successor: find pivot and successor, swap, reverse the tail
    always_comb begin
        has_pivot = 1'b0;
        k_i       = 0;
        s_i       = 0;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (perm[i] < perm[i+1]) begin
                has_pivot = 1'b1;
                k_i       = i;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (i > k_i && perm[i] > perm[k_i]) begin
                s_i = i;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            swapped[i] = perm[i];
        end
        swapped[k_i] = perm[s_i];
        swapped[s_i] = perm[k_i];
        for (int i = 0; i < int'(N); i++) begin
            perm_nxt[i] = (i > k_i) ? swapped[int'(N) + k_i - i] : swapped[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = FETCH;
            FETCH:   if (idx == IDX_LAST) state_nxt = UPDATE;
            UPDATE:  state_nxt = has_pivot ? FETCH : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        W     = '0;
        J     = '0;
        Busy  = 1'b0;
        Valid = 1'b0;
        case (state)
            FETCH: begin
                W    = idx;
                J    = perm[idx];
                Busy = 1'b1;
            end
            UPDATE: Busy = 1'b1;
            DONE: begin
                Busy  = 1'b1;
                Valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: permutation, fetch index, running sum and best-so-far tracking
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(N); i++) begin
                perm[i] <= IW'(i);
            end
            idx         <= '0;
            acc         <= '0;
            min_cost    <= MIN_INIT;
            match_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        for (int i = 0; i < int'(N); i++) begin
                            perm[i] <= IW'(i);
                        end
                        idx         <= '0;
                        acc         <= '0;
                        min_cost    <= MIN_INIT;
                        match_count <= '0;
                    end
                end
                FETCH: begin
                    acc <= acc + ACC_W'(Cost);
                    idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                end
                UPDATE: begin
                    if (acc < min_cost) begin
                        min_cost    <= acc;
                        match_count <= CNT_W'(1);
                    end else if (acc == min_cost) begin
                        match_count <= match_count + CNT_W'(1);
                    end
                    if (has_pivot) begin
                        perm <= perm_nxt;
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign MinCost    = min_cost;
    assign MatchCount = match_count;

endmodule

// File: doc/jam_perm_sched.md
# jam_perm_sched

Exhaustive-search scheduler for the job-assignment datapath: 8 workers × 8 jobs. It walks all 8! = 40320 worker→job permutations in lexicographic order. For each permutation it issues 8 cost-table reads (W, J), accumulates the returned costs, and tracks the minimum total and how many permutations reach it. It sits between the top-level START/Valid handshake and the external combinational cost ROM.

## Interface
- COST_W, 7, width of one cost entry; the 8-entry sum must fit in 10 bits.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  run request; sampled only in IDLE
- Cost  in  COST_W  cost-ROM data for the current (W, J); combinational, valid in the same cycle
- W  out  3  worker index to the ROM
- J  out  3  job index to the ROM
- Busy  out  1  high from the first FETCH cycle through DONE
- Valid  out  1  one-cycle pulse; results are final
- MatchCount  out  16  number of permutations whose total equals MinCost
- MinCost  out  10  minimum total cost found

## Operation
- Reset values:
  - W=0, J=0, Busy=0, Valid=0.
  - MatchCount=0, MinCost=10'h3FF.
  - perm[0..7]=0..7, idx=0, acc=0, state=IDLE.
- States: IDLE, FETCH, UPDATE, DONE.
- IDLE:
  - When START=1: reload perm=0..7, idx=0, acc=0, MinCost=10'h3FF, MatchCount=0. Next state is FETCH.
  - When START=0: stay in IDLE; outputs hold their last results.
- FETCH (8 cycles, idx=0..7):
  - W=idx, J=perm[idx].
  - acc += Cost, zero-extended to 10 bits.
  - idx increments each cycle; after idx=7, next state is UPDATE.
- UPDATE (1 cycle): compare first, then advance.
  - If acc < MinCost: MinCost=acc, MatchCount=1.
  - Else if acc == MinCost: MatchCount += 1. No saturation is needed; the maximum is 40320.
  - The compare uses the acc value that includes the 8th cost, i.e. the register value after the last FETCH.
  - Next permutation, computed combinationally in this one cycle:
    - Pivot k = largest index with perm[k] < perm[k+1].
    - Successor s = largest index > k with perm[s] > perm[k].
    - Swap perm[k] and perm[s], then reverse perm[k+1..7].
  - If no pivot exists (perm = 7,6,5,4,3,2,1,0), this was the last permutation. It is still compared; next state is DONE.
  - Otherwise: acc=0, idx=0, next state is FETCH.
- DONE (1 cycle): Valid=1, Busy=1. Next state is IDLE.
- Outside FETCH: W=0, J=0.
- Arithmetic: acc is 10 bits unsigned. The maximum sum is 8·127 = 1016 < 1023, so no overflow is possible. The first permutation always sets MatchCount=1.
- START while Busy is ignored; it does not restart the run.
- RST at any time, including mid-run:
  - Immediately returns every register to its reset value.
  - Valid is never emitted for the aborted run.

## Timing
- Cycle 0: START sampled high in IDLE.
- Cycle 1: first FETCH; W=0, J=0; Busy rises.
- Each permutation takes 9 cycles (8 FETCH + 1 UPDATE).
- The last UPDATE ends at cycle 362880.
- DONE occupies cycle 362881; Valid is high in that cycle.
- Cycle 362882: back in IDLE with Busy=0.
- Start-to-Valid latency: 362881 cycles.
- MatchCount and MinCost:
  - Update at the end of each UPDATE cycle.
  - Final and stable from the DONE cycle until the next accepted START.
- Permutation sequence:
  - First permutation: J = 0,1,2,3,4,5,6,7.
  - Second: 0,1,2,3,4,5,7,6.
  - Third: 0,1,2,3,4,6,5,7.
  - Last: 7,6,5,4,3,2,1,0.

## Test plan
- Constant Cost=5 for all (W, J), one START:
  - Expect Valid exactly 362881 cycles after the START cycle, MinCost=40, MatchCount=40320.
- Cost = (J==W) ? 0 : 100:
  - Expect MinCost=0, MatchCount=1.
  - The (W, J) sequence of the first 3 permutations must match the Timing list.
- Cost = (J==7-W) ? 0 : 100:
  - Expect MinCost=0, MatchCount=1.
  - This proves the last permutation (7..0) is compared.
- Cost = W·8+J from the contest-style table, compared against the reference model:
  - Every permutation totals 252, so expect MinCost=252, MatchCount=40320.
  - Also run a random table and check against a software brute-force result.
- START pulsed again at cycle 1000 of a run:
  - Run continues; results and Valid timing are identical to an undisturbed run.
- RST asserted at cycle 50000:
  - Outputs return to reset values immediately; no Valid pulse.
  - A new START then completes normally with correct results.
